// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: round count, key-schedule FSM encoding and the FK/CK
// constants used by the key-expansion round stage.
package sm4_pkg;

    localparam int SM4_ROUNDS     = 32;
    localparam int SM4_BANK_DEPTH = 32;
    localparam int SM4_BANK_AW    = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERR   = 2'd3
    } ks_state_e;

    // System parameter FK, applied by the stage to MK at round 0.
    localparam logic [127:0] SM4_FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    // CK[i] byte j = (4*i + j) * 7 mod 256, most significant byte first.
    function automatic logic [31:0] sm4_ck(input logic [SM4_BANK_AW-1:0] idx);
        logic [31:0] ck;
        logic [7:0]  base;
        base = {1'b0, idx, 2'b00};
        ck   = '0;
        for (int j = 0; j < 4; j++) begin
            ck[31-8*j -: 8] = 8'((base + 8'(j)) * 8'd7);
        end
        return ck;
    endfunction

endpackage

// File: rtl/sm4_rk_bank.sv
// 32x32 round-key register file: one write port, one registered read port that
// can reverse the index for decryption. Cleared by the asynchronous reset.
module sm4_rk_bank
    import sm4_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_we,
    input  logic [SM4_BANK_AW-1:0] i_waddr,
    input  logic [31:0]            i_wdata,
    input  logic [SM4_BANK_AW-1:0] i_raddr,
    input  logic                   i_rdecrypt,
    output logic [31:0]            o_rdata
);

    logic [31:0]            entry_q [SM4_BANK_DEPTH];
    logic [SM4_BANK_AW-1:0] raddr_eff;
    logic [31:0]            rdata_reg;

    // 31 - addr is the bitwise complement for a 5-bit index.
    assign raddr_eff = i_rdecrypt ? ~i_raddr : i_raddr;

    genvar gi;
    generate
        for (gi = 0; gi < SM4_BANK_DEPTH; gi++) begin : g_entry
            logic [31:0] entry_reg;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    entry_reg <= '0;
                end else if (i_we && (i_waddr == SM4_BANK_AW'(gi))) begin
                    entry_reg <= i_wdata;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    // Read samples pre-write contents, so a same-cycle write returns old data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdata_reg <= '0;
        end else begin
            rdata_reg <= entry_q[raddr_eff];
        end
    end

    assign o_rdata = rdata_reg;

endmodule

// File: rtl/sm4_key_sched_ctrl.sv
// SM4 key-expansion controller: drives the single-round stage through all
// rounds, banks each round key and serves them through a registered read port.
module sm4_key_sched_ctrl
    import sm4_pkg::*;
#(
    parameter int ROUNDS  = SM4_ROUNDS,
    parameter int TIMEOUT = 15
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [127:0] i_key,
    input  logic         i_key_valid,
    output logic         o_key_ready,
    output logic [7:0]   o_ks_round,
    output logic [127:0] o_ks_key,
    output logic         o_ks_valid,
    input  logic [31:0]  i_ks_rk,
    input  logic         i_ks_rk_valid,
    input  logic [127:0] i_ks_state,
    input  logic [4:0]   i_rd_addr,
    input  logic         i_rd_decrypt,
    output logic [31:0]  o_rd_rk,
    output logic         o_keys_ready,
    output logic         o_busy,
    output logic         o_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    ks_state_e    state_reg, state_next;
    logic [4:0]   round_reg, round_next;
    logic [127:0] kstate_reg, kstate_next;
    logic [TW-1:0] tcnt_reg, tcnt_next;
    logic         keys_ready_reg, keys_ready_next;
    logic         err_reg, err_next;
    logic         key_ready_reg;
    logic         ks_valid_reg;
    logic         busy_reg;
    logic         bank_we;

    always_comb begin
        state_next      = state_reg;
        round_next      = round_reg;
        kstate_next     = kstate_reg;
        tcnt_next       = tcnt_reg;
        keys_ready_next = keys_ready_reg;
        err_next        = err_reg;
        bank_we         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (i_key_valid && key_ready_reg) begin
                    kstate_next     = i_key;
                    round_next      = '0;
                    keys_ready_next = 1'b0;
                    err_next        = 1'b0;
                    state_next      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tcnt_next  = '0;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_ks_rk_valid) begin
                    bank_we     = 1'b1;
                    kstate_next = i_ks_state;
                    if (round_reg == 5'(ROUNDS - 1)) begin
                        keys_ready_next = 1'b1;
                        state_next      = ST_IDLE;
                    end else begin
                        round_next = round_reg + 5'd1;
                        state_next = ST_ISSUE;
                    end
                end else if (tcnt_reg == TW'(TIMEOUT - 1)) begin
                    // Raised on entry so the flag is already visible in ERR.
                    err_next   = 1'b1;
                    state_next = ST_ERR;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end
            ST_ERR: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= ST_IDLE;
            round_reg      <= '0;
            kstate_reg     <= '0;
            tcnt_reg       <= '0;
            keys_ready_reg <= 1'b0;
            err_reg        <= 1'b0;
            key_ready_reg  <= 1'b0;
            ks_valid_reg   <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            round_reg      <= round_next;
            kstate_reg     <= kstate_next;
            tcnt_reg       <= tcnt_next;
            keys_ready_reg <= keys_ready_next;
            err_reg        <= err_next;
            key_ready_reg  <= (state_next == ST_IDLE);
            ks_valid_reg   <= (state_next == ST_ISSUE);
            busy_reg       <= (state_next == ST_ISSUE) || (state_next == ST_WAIT);
        end
    end

    sm4_rk_bank u_bank (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_we       (bank_we),
        .i_waddr    (round_reg),
        .i_wdata    (i_ks_rk),
        .i_raddr    (i_rd_addr),
        .i_rdecrypt (i_rd_decrypt),
        .o_rdata    (o_rd_rk)
    );

    assign o_key_ready  = key_ready_reg;
    assign o_ks_round   = {3'b000, round_reg};
    assign o_ks_key     = kstate_reg;
    assign o_ks_valid   = ks_valid_reg;
    assign o_keys_ready = keys_ready_reg;
    assign o_busy       = busy_reg;
    assign o_err        = err_reg;

endmodule

// File: doc/sm4_key_sched_ctrl.md
Name: sm4_key_sched_ctrl

Overview:
Controller for the SM4 key-expansion round stage.
- Accepts a 128-bit master key (MK) and drives the single-round key-expansion stage through 32 rounds, feeding each returned 128-bit state back as the next round's input.
- Captures each round key rk0..rk31 into a 32x32 key bank.
- Serves the bank to the encryption/decryption round datapath through a registered read port, with forward (encrypt) or reversed (decrypt) indexing.

Parameters:
- ROUNDS, 32, number of key-expansion rounds; fixed by SM4, kept as a parameter for bench shortening only.
- TIMEOUT, 15, max cycles to wait for the stage's round-key return before flagging an error.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_key  in  128  master key MK
- i_key_valid  in  1  MK offer
- o_key_ready  out  1  high in IDLE only; transfer occurs on i_key_valid & o_key_ready
- o_ks_round  out  8  round index to stage (its i_i)
- o_ks_key  out  128  key state to stage (its i_Initial_Key)
- o_ks_valid  out  1  one-cycle issue pulse to stage (its i_Initial_valid)
- i_ks_rk  in  32  round key from stage (its o_Encrypt_Key)
- i_ks_rk_valid  in  1  round-key valid from stage (its o_Encrypt_valid)
- i_ks_state  in  128  next key state from stage (its o_K)
- i_rd_addr  in  5  round-key read index
- i_rd_decrypt  in  1  1: read rk[31-addr]; 0: read rk[addr]
- o_rd_rk  out  32  read data, 1-cycle latency
- o_keys_ready  out  1  all 32 round keys valid for the current MK
- o_busy  out  1  expansion in progress
- o_err  out  1  sticky timeout flag

Behaviour:
Reset values:
- All outputs 0, except o_key_ready, which is 1 one cycle after reset deassertion.
- State is IDLE; key bank cleared to 0.

States: IDLE, ISSUE, WAIT, ERR.
- IDLE: o_key_ready=1.
  - On accept, latch MK into the state register, set round=0, clear o_keys_ready and o_err, then go to ISSUE.
- ISSUE: o_ks_valid=1 for exactly one cycle; o_ks_round=round; o_ks_key=state register. Then go to WAIT and clear the timeout counter.
- o_ks_round and o_ks_key hold stable from ISSUE until the matching return. The stage samples i_i combinationally over several cycles, so this is mandatory.
- Round 0 sends raw MK; the stage applies FK itself when i_i==0. The controller never XORs FK.
- WAIT: on i_ks_rk_valid:
  - write i_ks_rk to bank[round];
  - load i_ks_state into the state register.
  - If round==ROUNDS-1: set o_keys_ready=1 and go to IDLE.
  - Else: round+1, go to ISSUE.
- WAIT timeout: counter reaches TIMEOUT without a return -> go to ERR.
- ERR: set o_err=1 for one cycle in this state (sticky thereafter); o_keys_ready stays 0; go to IDLE.
- o_busy=1 in ISSUE and WAIT.
- i_ks_rk_valid outside WAIT is ignored: no bank write, no state change.
- i_key_valid outside IDLE is ignored; MK is not latched.
- Throughput: per-round cost is the stage latency L plus 1 issue cycle. With L=4, total is 32*5 = 160 cycles from accept to o_keys_ready.

Read port:
- o_rd_rk registered every cycle from bank[i_rd_decrypt ? 31-i_rd_addr : i_rd_addr].
- Reads are always allowed. Content is only meaningful while o_keys_ready=1.
- A read and a write to the same entry in the same cycle return the old value.

Reset mid-operation: immediate return to IDLE, bank cleared, o_keys_ready=0. No issue pulse is emitted afterwards.

Width rules: round counter is 5 bits, zero-extended onto o_ks_round. Timeout counter width is $clog2(TIMEOUT+1).

Decomposition:
- sm4_pkg: ROUNDS constant, FSM state enum, SM4 FK/CK constants (shared with the key-expansion stage).
- One sub-module, sm4_rk_bank: 32x32 register file with async clear, one write port, one registered read port with the decrypt index-reversal.

Test Plan:
- Standard vector: MK=0123456789ABCDEFFEDCBA9876543210, with the real stage instance connected -> bank[0]=F12186F9, bank[31]=9124A012; o_keys_ready rises 160 cycles after accept (L=4).
- Decrypt read: after the vector, i_rd_addr=0, i_rd_decrypt=1 -> o_rd_rk=9124A012 next cycle; with i_rd_decrypt=0 -> F12186F9.
- Hold check: stub stage with L=7 -> o_ks_round/o_ks_key constant for all 7 WAIT cycles each round; exactly 32 o_ks_valid pulses.
- Timeout: stub never returns valid -> o_err=1 at cycle 1+TIMEOUT after the first issue; back in IDLE with o_key_ready=1 and o_keys_ready=0; the next accepted key clears o_err.
- Spurious/overlap: i_ks_rk_valid pulsed in IDLE -> bank unchanged; i_key_valid during WAIT -> ignored, round sequence unaffected.
- Reset at round 10 -> o_busy=0, o_keys_ready=0, all bank reads return 0; a new MK then expands correctly.
